// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction front end.
// Holds the PC, fetches words over a req/ack instruction-memory handshake,
// presents them downstream with valid/ready, and applies jump/branch
// redirects resolved by decode/ALU.
// Optional build macro: INSTR_FETCH_DELAY_SLOT_EN enables the MIPS branch
// delay slot (the word after a taken branch/jump is always issued).
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic              redirect_jump,
    input  logic              redirect_branch,
    input  logic              alu_zero,
    input  logic [15:0]       br_offset,
    input  logic [25:0]       jmp_index
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(3'd4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic              dslot_pend_q, dslot_pend_d;

    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] jump_tgt_s;
    logic [ADDR_W-1:0] br_tgt_s;
    logic [ADDR_W-1:0] target_s;
    logic              taken_s;
    logic              accept_s;
    logic              new_req_s;

    // Redirect decision and target, relative to the word after the last accepted instruction
    always_comb begin
        seq_pc_s   = last_pc_q + WORD_STEP;
        jump_tgt_s = {seq_pc_s[ADDR_W-1:28], jmp_index, 2'b00};
        br_tgt_s   = seq_pc_s + {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
        taken_s    = redirect_valid & (redirect_jump | (redirect_branch & alu_zero));
        if (redirect_jump) begin
            target_s = jump_tgt_s;
        end else begin
            target_s = br_tgt_s;
        end
    end

    // Next-state, PC and held-word update for the fetch sequencer
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        last_pc_d    = last_pc_q;
        dslot_pend_d = dslot_pend_q;
        accept_s     = valid_q & instr_ready;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (taken_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
            end

            S_FETCH: begin
`ifdef INSTR_FETCH_DELAY_SLOT_EN
                // In-flight word is the delay slot: always kept.
                if (imem_ack) begin
                    instr_d      = imem_rdata;
                    instr_pc_d   = addr_q;
                    state_d      = S_HOLD;
                    dslot_pend_d = 1'b0;
                    if (taken_s) begin
                        pc_d = target_s;
                    end else if (dslot_pend_q) begin
                        pc_d = pc_q;           // already holds the redirect target
                    end else begin
                        pc_d = pc_q + WORD_STEP;
                    end
                end else begin
                    state_d = S_FETCH;
                    if (taken_s) begin
                        pc_d         = target_s;
                        dslot_pend_d = 1'b1;
                    end else begin
                        pc_d = pc_q;
                    end
                end
`else
                if (taken_s) begin
                    // Wrong-path fetch: discard it now or drain it later.
                    pc_d = target_s;
                    if (imem_ack) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = addr_q;
                    pc_d       = pc_q + WORD_STEP;
                    state_d    = S_HOLD;
                end else begin
                    state_d = S_FETCH;
                end
`endif
            end

            S_HOLD: begin
`ifdef INSTR_FETCH_DELAY_SLOT_EN
                if (taken_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (accept_s) begin
                    last_pc_d = instr_pc_q;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
`else
                if (taken_s) begin
                    pc_d    = target_s;        // held word is on the wrong path
                    state_d = S_FETCH;
                end else if (accept_s) begin
                    last_pc_d = instr_pc_q;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
`endif
            end

            S_DRAIN: begin
                if (taken_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ack) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DRAIN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave a flop.
        req_d     = (state_d == S_FETCH) || (state_d == S_DRAIN);
        valid_d   = (state_d == S_HOLD);
        // Address only moves when a new request starts, keeping it stable under req.
        new_req_s = req_d & (~req_q | imem_ack);
        if (new_req_s) begin
            addr_d = pc_d;
        end else begin
            addr_d = addr_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0000_0000;
            instr_pc_q   <= {ADDR_W{1'b0}};
            last_pc_q    <= {ADDR_W{1'b0}};
            dslot_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            last_pc_q    <= last_pc_d;
            dslot_pend_q <= dslot_pend_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;

endmodule
